// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage between pc_counter and the IF/ID boundary.
// Fetches one word at a time over a req/ack handshake, loads the IF/ID register,
// and computes the next PC (jump > branch > sequential).
// Optional build macro: FETCH_ALIGN_CHECK_EN adds a sticky fetch_misalign output
// and blocks requests to misaligned addresses; without it the low address bits
// are forced to zero on every request.
module fetch_unit #(
  parameter int unsigned ADDR_W   = 32,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] current,
  output logic [ADDR_W-1:0] next_addr,
  input  logic              hazardStall,
  output logic              fetch_stall,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic              fetch_misalign,
`endif
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump_en,
  input  logic [25:0]       jump_index,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [ADDR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc4,
  output logic              ifid_valid
);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN, HOLD} state_t;

  state_t            state_q;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] instr_q;
  logic [ADDR_W-1:0] pc4_q;
  logic              valid_q;
  logic [ADDR_W-1:0] holdInstr_q;
  logic [ADDR_W-1:0] holdPc4_q;
`ifdef FETCH_ALIGN_CHECK_EN
  logic              misalign_q;
  logic              latchMis;
`endif

  logic              redirect;
  logic              ackEff;
  logic              latchEn;
  logic [ADDR_W-1:0] latchSrc;
  logic [ADDR_W-1:0] latchAddr;

  // An ack only counts while a request is actually outstanding.
  assign redirect = jump_en | branch_taken;
  assign ackEff   = imem_ack & req_q;

  // Next PC for pc_counter: jump wins over branch, otherwise fall through by one word.
  always_comb begin
    next_addr = current + 32'd4;
    if (jump_en) begin
      next_addr = {ifid_pc4[31:28], jump_index, 2'b00};
    end else if (branch_taken) begin
      next_addr = branch_target;
    end
  end

  // Fetch is incomplete unless a word is being returned, or we are parked in HOLD.
  always_comb begin
    fetch_stall = 1'b1;
    case (state_q)
      REQ:     fetch_stall = ~ackEff;
      HOLD:    fetch_stall = 1'b0;
      default: fetch_stall = 1'b1;
    endcase
  end

  // Decide whether a new fetch address is captured this cycle and where it comes from.
  always_comb begin
    latchEn  = 1'b0;
    latchSrc = current;
    case (state_q)
      IDLE: latchEn = 1'b1;
      REQ: begin
        if (redirect) begin
          if (ackEff || !req_q) begin
            latchEn  = 1'b1;
            latchSrc = next_addr;
          end
        end else if (ackEff && !hazardStall) begin
          latchEn  = 1'b1;
          latchSrc = next_addr;
        end
      end
      DRAIN: latchEn = ackEff;
      HOLD: begin
        if (redirect) begin
          latchEn  = 1'b1;
          latchSrc = next_addr;
        end else if (!hazardStall) begin
          latchEn = 1'b1;
        end
      end
      default: latchEn = 1'b0;
    endcase
  end

  // Alignment handling of a captured address: flag it, or silently word-align it.
`ifdef FETCH_ALIGN_CHECK_EN
  always_comb begin
    latchAddr = latchSrc;
    latchMis  = |latchSrc[1:0];
  end
`else
  always_comb begin
    latchAddr = latchSrc & 32'hFFFF_FFFC;
  end
`endif

  // Fetch FSM together with the IF/ID register and the hold buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      addr_q      <= '0;
      instr_q     <= NOP_WORD;
      pc4_q       <= '0;
      valid_q     <= 1'b0;
      holdInstr_q <= '0;
      holdPc4_q   <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      if (latchEn) begin
        addr_q <= latchAddr;
`ifdef FETCH_ALIGN_CHECK_EN
        req_q      <= ~latchMis;
        misalign_q <= misalign_q | latchMis;
`else
        req_q <= 1'b1;
`endif
      end
      case (state_q)
        IDLE: state_q <= REQ;
        REQ: begin
          if (redirect) begin
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
            if (req_q && !ackEff) begin
              state_q <= DRAIN;
            end
          end else if (ackEff) begin
            if (hazardStall) begin
              holdInstr_q <= imem_rdata;
              holdPc4_q   <= addr_q + 32'd4;
              req_q       <= 1'b0;
              state_q     <= HOLD;
            end else begin
              instr_q <= imem_rdata;
              pc4_q   <= addr_q + 32'd4;
              valid_q <= 1'b1;
            end
          end else if (!hazardStall) begin
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (ackEff) begin
            state_q <= REQ;
          end
        end
        HOLD: begin
          if (redirect) begin
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
            state_q <= REQ;
          end else if (!hazardStall) begin
            instr_q <= holdInstr_q;
            pc4_q   <= holdPc4_q;
            valid_q <= 1'b1;
            state_q <= REQ;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign ifid_instr = instr_q;
  assign ifid_pc4   = pc4_q;
  assign ifid_valid = valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
  assign fetch_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a vector table for next_addr, then directed
// sequences driven against a simple pc_counter and instruction-memory model, with
// expected IF/ID contents queued as fetches are issued and popped when they land.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] current;
  logic [31:0] next_addr;
  logic        hazardStall;
  logic        fetch_stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump_en;
  logic [25:0] jump_index;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_misalign;
`endif

  int testsRun    = 0;
  int testsFailed = 0;

  // pc_counter model: redirects always load, otherwise advance unless stalled
  logic        pcAuto;
  logic [31:0] pcInit;
  logic [31:0] pcManual;
  logic [31:0] pcReg;

  // instruction memory model: ack after ackDelay wait cycles
  int ackDelay = 0;
  int waitCnt  = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [31:0] cur;
    logic        br;
    logic [31:0] tgt;
    logic        jmp;
    logic [25:0] idx;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[6];

  fetch_unit #(.ADDR_W(32), .NOP_WORD(32'h0000_0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .current       (current),
    .next_addr     (next_addr),
    .hazardStall   (hazardStall),
    .fetch_stall   (fetch_stall),
`ifdef FETCH_ALIGN_CHECK_EN
    .fetch_misalign(fetch_misalign),
`endif
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump_en       (jump_en),
    .jump_index    (jump_index),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .ifid_instr    (ifid_instr),
    .ifid_pc4      (ifid_pc4),
    .ifid_valid    (ifid_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instrOf(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  assign imem_rdata = instrOf(imem_addr);
  assign imem_ack   = imem_req && (waitCnt >= ackDelay);
  assign current    = pcAuto ? pcReg : pcManual;

  always @(posedge clk or negedge reset) begin
    if (!reset) waitCnt <= 0;
    else if (imem_req && !imem_ack) waitCnt <= waitCnt + 1;
    else waitCnt <= 0;
  end

  always @(posedge clk) begin
    if (!reset) pcReg <= pcInit;
    else if (branch_taken || jump_en || !(fetch_stall || hazardStall)) pcReg <= next_addr;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pushExp(input logic [31:0] a);
    exp_t e;
    e.instr = instrOf(a);
    e.pc4   = a + 32'd4;
    sbq.push_back(e);
  endtask

  task automatic popCompare(input string name);
    exp_t e;
    if (sbq.size() == 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s: got IF/ID load expected empty scoreboard", name);
    end else begin
      e = sbq.pop_front();
      checkOutput({name, "_valid"}, {31'b0, ifid_valid}, 32'd1);
      checkOutput({name, "_instr"}, ifid_instr, e.instr);
      checkOutput({name, "_pc4"}, ifid_pc4, e.pc4);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int i);
    pcManual      = v.cur;
    branch_taken  = v.br;
    branch_target = v.tgt;
    jump_en       = v.jmp;
    jump_index    = v.idx;
    #1;
    checkOutput($sformatf("vec%0d_next_addr", i), next_addr, v.exp);
  endtask

  task automatic doReset(input logic [31:0] start, input int delay);
    reset = 1'b0;
    #1;
    checkOutput("rstReqDrop", {31'b0, imem_req}, 32'd0);
    pcAuto        = 1'b1;
    pcInit        = start;
    ackDelay      = delay;
    hazardStall   = 1'b0;
    branch_taken  = 1'b0;
    jump_en       = 1'b0;
    branch_target = 32'h0;
    jump_index    = 26'h0;
    sbq.delete();
    step();
    checkOutput("rst_req", {31'b0, imem_req}, 32'd0);
    checkOutput("rst_addr", imem_addr, 32'h0);
    checkOutput("rst_instr", ifid_instr, 32'h0);
    checkOutput("rst_pc4", ifid_pc4, 32'h0);
    checkOutput("rst_valid", {31'b0, ifid_valid}, 32'd0);
    checkOutput("rst_stall", {31'b0, fetch_stall}, 32'd1);
`ifdef FETCH_ALIGN_CHECK_EN
    checkOutput("rst_misalign", {31'b0, fetch_misalign}, 32'd0);
`endif
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset         = 1'b0;
    pcAuto        = 1'b0;
    pcInit        = 32'h0;
    pcManual      = 32'h0;
    hazardStall   = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    jump_en       = 1'b0;
    jump_index    = 26'h0;
    step();
    step();

    // next_addr priority table, evaluated while held in reset (ifid_pc4 = 0)
    vecs[0] = '{cur: 32'h0000_3000, br: 1'b0, tgt: 32'h0,         jmp: 1'b0, idx: 26'h0,       exp: 32'h0000_3004};
    vecs[1] = '{cur: 32'hFFFF_FFFC, br: 1'b0, tgt: 32'h0,         jmp: 1'b0, idx: 26'h0,       exp: 32'h0000_0000};
    vecs[2] = '{cur: 32'h0000_3000, br: 1'b1, tgt: 32'h0000_3100, jmp: 1'b0, idx: 26'h0,       exp: 32'h0000_3100};
    vecs[3] = '{cur: 32'h0000_3000, br: 1'b0, tgt: 32'h0,         jmp: 1'b1, idx: 26'h0000C40, exp: 32'h0000_3100};
    vecs[4] = '{cur: 32'h0000_1234, br: 1'b1, tgt: 32'hDEAD_BEE0, jmp: 1'b1, idx: 26'h3FFFFFF, exp: 32'h0FFF_FFFC};
    vecs[5] = '{cur: 32'h7FFF_FFFC, br: 1'b0, tgt: 32'hAAAA_0000, jmp: 1'b0, idx: 26'h0,       exp: 32'h8000_0000};
    for (int i = 0; i < 6; i++) applyStimulus(vecs[i], i);

    // back-to-back fetch with single-cycle memory, then a jump that hits an ack
    doReset(32'h0000_3000, 0);
    step();
    checkOutput("seq_addr0", imem_addr, 32'h0000_3000);
    checkOutput("seq_valid0", {31'b0, ifid_valid}, 32'd0);
    pushExp(32'h0000_3000);
    for (int i = 1; i <= 4; i++) begin
      step();
      checkOutput($sformatf("seq_addr%0d", i), imem_addr, 32'h0000_3000 + 32'(4 * i));
      popCompare($sformatf("seq_ifid%0d", i));
      pushExp(32'h0000_3000 + 32'(4 * i));
    end
    jump_en    = 1'b1;
    jump_index = 26'h0000C40;
    #1;
    checkOutput("jump_next_addr", next_addr, 32'h0000_3100);
    step();
    jump_en = 1'b0;
    checkOutput("jumpAck_valid", {31'b0, ifid_valid}, 32'd0);
    checkOutput("jumpAck_instr", ifid_instr, 32'h0);
    checkOutput("jumpAck_addr", imem_addr, 32'h0000_3100);

    // three-cycle memory latency
    doReset(32'h0000_3000, 3);
    step();
    pushExp(32'h0000_3000);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("slow_addr%0d", i), imem_addr, 32'h0000_3000);
      checkOutput($sformatf("slow_stall%0d", i), {31'b0, fetch_stall}, 32'd1);
      checkOutput($sformatf("slow_valid%0d", i), {31'b0, ifid_valid}, 32'd0);
      step();
    end
    checkOutput("slow_ackStall", {31'b0, fetch_stall}, 32'd0);
    step();
    popCompare("slow_ifid");

    // hazard stall on the ack cycle parks the word in HOLD
    doReset(32'h0000_3000, 0);
    step();
    pushExp(32'h0000_3000);
    hazardStall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checkOutput($sformatf("hold_req%0d", i), {31'b0, imem_req}, 32'd0);
      checkOutput($sformatf("hold_valid%0d", i), {31'b0, ifid_valid}, 32'd0);
      checkOutput($sformatf("hold_instr%0d", i), ifid_instr, 32'h0);
      checkOutput($sformatf("hold_stall%0d", i), {31'b0, fetch_stall}, 32'd0);
    end
    pcAuto      = 1'b0;
    pcManual    = 32'h0000_3004;
    hazardStall = 1'b0;
    step();
    popCompare("hold_release");
    checkOutput("hold_relAddr", imem_addr, 32'h0000_3004);
    checkOutput("hold_relReq", {31'b0, imem_req}, 32'd1);

    // branch while a slow request is pending: drain, discard, refetch at target
    doReset(32'h0000_3000, 0);
    step();
    pushExp(32'h0000_3000);
    step();
    popCompare("br_ifid0");
    pushExp(32'h0000_3004);
    step();
    popCompare("br_ifid1");
    checkOutput("br_pendAddr", imem_addr, 32'h0000_3008);
    ackDelay      = 2;
    branch_taken  = 1'b1;
    branch_target = 32'h0000_3100;
    step();
    branch_taken = 1'b0;
    checkOutput("drain_valid", {31'b0, ifid_valid}, 32'd0);
    checkOutput("drain_addr0", imem_addr, 32'h0000_3008);
    checkOutput("drain_req", {31'b0, imem_req}, 32'd1);
    checkOutput("drain_stall0", {31'b0, fetch_stall}, 32'd1);
    step();
    checkOutput("drain_addr1", imem_addr, 32'h0000_3008);
    checkOutput("drain_stall1", {31'b0, fetch_stall}, 32'd1);
    step();
    checkOutput("drain_newAddr", imem_addr, 32'h0000_3100);
    checkOutput("drain_discard", {31'b0, ifid_valid}, 32'd0);
    ackDelay = 0;
    pushExp(32'h0000_3100);
    step();
    popCompare("br_target_ifid");

    // address wrap at the top of memory, and jump keeping the PC's upper nibble
    doReset(32'hFFFF_FFF8, 0);
    step();
    pushExp(32'hFFFF_FFF8);
    step();
    popCompare("wrap_ifid0");
    pushExp(32'hFFFF_FFFC);
    checkOutput("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    jump_en    = 1'b1;
    jump_index = 26'h0000001;
    #1;
    checkOutput("wrap_jump", next_addr, 32'hF000_0004);
    jump_en = 1'b0;
    #1;
    step();
    popCompare("wrap_ifid1");
    checkOutput("wrap_addr1", imem_addr, 32'h0000_0000);

    // misaligned PC handling
    doReset(32'h0000_3002, 0);
    step();
`ifdef FETCH_ALIGN_CHECK_EN
    checkOutput("mis_req", {31'b0, imem_req}, 32'd0);
    checkOutput("mis_flag", {31'b0, fetch_misalign}, 32'd1);
    step();
    checkOutput("mis_reqWait", {31'b0, imem_req}, 32'd0);
    checkOutput("mis_valid", {31'b0, ifid_valid}, 32'd0);
    checkOutput("mis_stall", {31'b0, fetch_stall}, 32'd1);
    branch_taken  = 1'b1;
    branch_target = 32'h0000_3100;
    step();
    branch_taken = 1'b0;
    checkOutput("mis_recAddr", imem_addr, 32'h0000_3100);
    checkOutput("mis_recReq", {31'b0, imem_req}, 32'd1);
    checkOutput("mis_sticky", {31'b0, fetch_misalign}, 32'd1);
`else
    checkOutput("align_addr", imem_addr, 32'h0000_3000);
    checkOutput("align_req", {31'b0, imem_req}, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
